// File: rtl/md_force_pkg.sv
// Shared types and default geometry for the force write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Constants carry an MD_ prefix so importing modules can still declare
// parameters with the short names without colliding with the wildcard import.
package md_force_pkg;

  localparam int MD_DATA_WIDTH        = 32;
  localparam int MD_CELL_ID_WIDTH     = 3;
  localparam int MD_PARTICLE_ID_WIDTH = 7;
  localparam int MD_NUM_FILTER        = 7;
  localparam int MD_ID_WIDTH          = 3*MD_CELL_ID_WIDTH + MD_PARTICLE_ID_WIDTH;
  localparam int MD_WB_WIDTH          = MD_ID_WIDTH + 3*MD_DATA_WIDTH;
  localparam int MD_NUM_SLOTS         = 2*MD_NUM_FILTER - 1;

  // Cell id {x,y,z} = {2,2,2}: a reference id from this cell marks phase 0.
  localparam logic [3*MD_CELL_ID_WIDTH-1:0] MD_HOME_CELL = 9'b010010010;

  // Write-back packet; field order gives the flat layout {id,z,y,x}.
  typedef struct packed {
    logic [MD_ID_WIDTH-1:0]   id;
    logic [MD_DATA_WIDTH-1:0] fz;
    logic [MD_DATA_WIDTH-1:0] fy;
    logic [MD_DATA_WIDTH-1:0] fx;
  } wb_pkt_t;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_WAIT   = 2'd1,
    ST_WB_REF = 2'd2
  } fd_state_t;

endpackage

// File: rtl/fd_sync_fifo.sv
// Generic synchronous FIFO with show-ahead read data and full/empty flags.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: a push while full is ignored unless a pop happens the same cycle.
//
// Ports: clk, rst (async, active-low), push/push_dat, pop/pop_dat, full, empty.
module fd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign pop_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/force_wb_distributor.sv
// Streams neighbour forces and bursts captured reference forces onto the write-back bus.
// Latency: neighbour push to wb_valid is 2 cycles when the FIFO is empty and the output is free.
// Backpressure: wb_out/wb_valid hold while !ready; a neighbour push into a full FIFO is dropped.
//
// Ports: clk, rst (async, active-low), start_wb; ref_force_x/y/z, ref_id, ref_force_valid
// (NUM_FILTER channels); force_x/y/z, nb_id, force_valid (neighbour); ready;
// wb_out {id,z,y,x}, wb_valid, all_ref_wb_issued, busy, nb_overflow, ref_drop.
// Build option FD_SKIP_EMPTY_EN: the reference burst jumps straight to valid slots
// instead of spending one cycle on every slot.
module force_wb_distributor
  import md_force_pkg::*;
#(
  parameter int DATA_WIDTH        = MD_DATA_WIDTH,
  parameter int CELL_ID_WIDTH     = MD_CELL_ID_WIDTH,
  parameter int PARTICLE_ID_WIDTH = MD_PARTICLE_ID_WIDTH,
  parameter int NUM_FILTER        = MD_NUM_FILTER,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
  parameter int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH,
  parameter int NUM_SLOTS         = 2*NUM_FILTER - 1,
  parameter int NB_FIFO_DEPTH     = 8,
  parameter int WAIT_CYCLES       = 5,
  parameter logic [3*CELL_ID_WIDTH-1:0] HOME_CELL = MD_HOME_CELL
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_wb,
  input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_force_x,
  input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_force_y,
  input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_force_z,
  input  logic [NUM_FILTER-1:0][ID_WIDTH-1:0]   ref_id,
  input  logic [NUM_FILTER-1:0]                 ref_force_valid,
  input  logic [DATA_WIDTH-1:0]                 force_x,
  input  logic [DATA_WIDTH-1:0]                 force_y,
  input  logic [DATA_WIDTH-1:0]                 force_z,
  input  logic [ID_WIDTH-1:0]                   nb_id,
  input  logic                                  force_valid,
  input  logic                                  ready,
  output logic [WB_WIDTH-1:0]                   wb_out,
  output logic                                  wb_valid,
  output logic                                  all_ref_wb_issued,
  output logic                                  busy,
  output logic                                  nb_overflow,
  output logic                                  ref_drop
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
  localparam int CELL_W = 3*CELL_ID_WIDTH;

  fd_state_t state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [WB_WIDTH-1:0] fifo_dat;
  logic                out_free;

  logic                                phase0, cap_en, in_wb;
  logic [NUM_SLOTS-1:0]                slot_vld, cap_we, ref_sel, ref_clr;
  logic [NUM_SLOTS-1:0][WB_WIDTH-1:0]  cap_pkt;
  logic [WB_WIDTH-1:0]                 slot_dat [NUM_SLOTS];
  logic [SLOT_W-1:0]                   ref_idx;
  logic                                ref_cur_vld, ref_load, ref_done;

  assign in_wb    = (state == ST_WB_REF);
  assign busy     = (state != ST_ACTIVE);
  // Output register may take a new beat when empty or emptying this cycle.
  assign out_free = !wb_valid || ready;

  // ---------------- neighbour path ----------------
  fd_sync_fifo #(.WIDTH(WB_WIDTH), .DEPTH(NB_FIFO_DEPTH)) u_nb_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (force_valid),
    .push_dat ({nb_id, force_z, force_y, force_x}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Reference beats own the output while the burst wants it.
  assign fifo_pop = out_free && !fifo_empty && !ref_load;

  // ---------------- reference capture ----------------
  assign phase0 = ref_force_valid[0] && (ref_id[0][ID_WIDTH-1 -: CELL_W] == HOME_CELL);
  assign cap_en = !in_wb;

  // Slot s is fed by exactly one channel in exactly one phase:
  // phase 0 fills slots 0..NF-2 from channels 1..NF-1, phase 1 fills NF-1..2NF-2 from 0..NF-1.
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    localparam bit SLOT_PH0 = (s < NUM_FILTER-1);
    localparam int SLOT_CH  = SLOT_PH0 ? s + 1 : s - (NUM_FILTER-1);
    assign cap_we[s]  = cap_en && (phase0 == SLOT_PH0) && ref_force_valid[SLOT_CH];
    assign cap_pkt[s] = {ref_id[SLOT_CH], ref_force_z[SLOT_CH],
                         ref_force_y[SLOT_CH], ref_force_x[SLOT_CH]};
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (cap_we[s]) slot_dat[s] <= cap_pkt[s];
    end
  end

  // Capture and clear never coincide: capture is off during the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) slot_vld <= '0;
    else      slot_vld <= (slot_vld | cap_we) & ~ref_clr;
  end

  // ---------------- reference burst walker ----------------
  assign ref_sel     = NUM_SLOTS'(1) << ref_idx;
  assign ref_cur_vld = |(slot_vld & ref_sel);
  assign ref_load    = in_wb && ref_cur_vld && out_free;
  assign ref_clr     = ref_load ? ref_sel : '0;

`ifdef FD_SKIP_EMPTY_EN
  // Lowest valid slot first; with nothing valid the burst ends at once.
  always_comb begin
    ref_idx = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (slot_vld[i]) ref_idx = SLOT_W'(i);
    end
  end
  assign ref_done = in_wb && (!ref_cur_vld || (out_free && ((slot_vld & ~ref_sel) == '0)));
`else
  // Fixed walk over every slot; an empty slot still costs one cycle.
  logic [SLOT_W-1:0] ref_idx_q;
  logic              ref_step;

  assign ref_idx  = ref_idx_q;
  assign ref_step = in_wb && (!ref_cur_vld || out_free);
  assign ref_done = ref_step && (ref_idx_q == SLOT_W'(NUM_SLOTS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  ref_idx_q <= '0;
    else if (!in_wb || ref_done) ref_idx_q <= '0;
    else if (ref_step)         ref_idx_q <= ref_idx_q + 1'b1;
  end
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ACTIVE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_ACTIVE: begin
        if (start_wb) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        // The burst starts only after the neighbour stream has been quiet long enough.
        if ((wait_cnt == CNT_W'(WAIT_CYCLES)) && fifo_empty) state_nxt = ST_WB_REF;
        else if (force_valid || !fifo_empty)                  wait_cnt_nxt = '0;
        else                                                  wait_cnt_nxt = wait_cnt + 1'b1;
      end
      ST_WB_REF: begin
        if (ref_done) state_nxt = ST_ACTIVE;
      end
      default: state_nxt = ST_ACTIVE;
    endcase
  end

  // ---------------- output register and flags ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_out   <= '0;
      wb_valid <= 1'b0;
    end else if (out_free) begin
      if (ref_load) begin
        wb_out   <= slot_dat[ref_idx];
        wb_valid <= 1'b1;
      end else if (fifo_pop) begin
        wb_out   <= fifo_dat;
        wb_valid <= 1'b1;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      all_ref_wb_issued <= 1'b0;
      nb_overflow       <= 1'b0;
      ref_drop          <= 1'b0;
    end else begin
      all_ref_wb_issued <= in_wb && ref_done;
      // A push into a full FIFO survives only if a pop frees a word the same cycle.
      nb_overflow       <= nb_overflow | (force_valid && fifo_full && !fifo_pop);
      ref_drop          <= ref_drop | (in_wb && (|ref_force_valid));
    end
  end

endmodule

// File: tb/tb_force_wb_distributor.sv
// Directed bench for force_wb_distributor with hand-derived expectations.
module tb_force_wb_distributor;
  import md_force_pkg::*;

  localparam int NF = MD_NUM_FILTER;
  localparam int DW = MD_DATA_WIDTH;
  localparam int IW = MD_ID_WIDTH;
  localparam int WW = MD_WB_WIDTH;
  localparam int NS = MD_NUM_SLOTS;
`ifdef FD_SKIP_EMPTY_EN
  localparam int DROP_AT = 8;
`else
  localparam int DROP_AT = 10;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_wb;
  logic [NF-1:0][DW-1:0]  ref_force_x, ref_force_y, ref_force_z;
  logic [NF-1:0][IW-1:0]  ref_id;
  logic [NF-1:0]          ref_force_valid;
  logic [DW-1:0]          force_x, force_y, force_z;
  logic [IW-1:0]          nb_id;
  logic                   force_valid;
  logic                   ready;
  logic [WW-1:0]          wb_out;
  logic                   wb_valid, all_ref_wb_issued, busy, nb_overflow, ref_drop;

  always #5 clk = ~clk;

  force_wb_distributor dut (
    .clk(clk), .rst(rst), .start_wb(start_wb),
    .ref_force_x(ref_force_x), .ref_force_y(ref_force_y), .ref_force_z(ref_force_z),
    .ref_id(ref_id), .ref_force_valid(ref_force_valid),
    .force_x(force_x), .force_y(force_y), .force_z(force_z),
    .nb_id(nb_id), .force_valid(force_valid), .ready(ready),
    .wb_out(wb_out), .wb_valid(wb_valid), .all_ref_wb_issued(all_ref_wb_issued),
    .busy(busy), .nb_overflow(nb_overflow), .ref_drop(ref_drop)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Monitor state, written only by the negedge monitor.
  logic [WW-1:0] beats[$];
  int            beat_cyc[$];
  int            issued_cnt = 0;
  int            iss_cyc = 0;
  int            hold_err = 0;
  logic          hold_q = 1'b0;
  logic [WW-1:0] hold_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q && (!wb_valid || wb_out !== hold_dat)) hold_err <= hold_err + 1;
      if (wb_valid && ready) begin
        beats.push_back(wb_out);
        beat_cyc.push_back(cyc);
      end
      if (all_ref_wb_issued) begin
        issued_cnt <= issued_cnt + 1;
        iss_cyc    <= cyc;
      end
      hold_q   <= wb_valid && !ready;
      hold_dat <= wb_out;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] pkt(input logic [IW-1:0] id, input logic [DW-1:0] z,
                                        input logic [DW-1:0] y, input logic [DW-1:0] x);
    wb_pkt_t p;
    p.id = id; p.fz = z; p.fy = y; p.fx = x;
    return p;
  endfunction

  function automatic logic [WW-1:0] nb_pkt(input logic [IW-1:0] id);
    return pkt(id, {16'hC0C0, id}, {16'hB0B0, id}, {16'hA0A0, id});
  endfunction

  function automatic logic [DW-1:0] rv(input logic [7:0] tag, input logic [7:0] comp, input int ch);
    return {tag, comp, 16'(ch)};
  endfunction

  task automatic drive_nb(input logic [IW-1:0] id);
    force_valid = 1'b1;
    nb_id   = id;
    force_x = {16'hA0A0, id};
    force_y = {16'hB0B0, id};
    force_z = {16'hC0C0, id};
  endtask

  // One capture cycle; channel 0 carries the home cell when home is set.
  task automatic drive_ref(input logic [7:0] tag, input logic [IW-1:0] id_base,
                           input logic [NF-1:0] vld, input bit home);
    for (int i = 0; i < NF; i++) begin
      ref_id[i]      = id_base + IW'(i);
      ref_force_x[i] = rv(tag, 8'h0A, i);
      ref_force_y[i] = rv(tag, 8'h0B, i);
      ref_force_z[i] = rv(tag, 8'h0C, i);
    end
    if (home) ref_id[0] = {MD_HOME_CELL, {MD_PARTICLE_ID_WIDTH{1'b0}}};
    ref_force_valid = vld;
    tick();
    ref_force_valid = '0;
  endtask

  function automatic logic [WW-1:0] ref_pkt(input logic [7:0] tag, input logic [IW-1:0] id_base, input int ch);
    return pkt(id_base + IW'(ch), rv(tag, 8'h0C, ch), rv(tag, 8'h0B, ch), rv(tag, 8'h0A, ch));
  endfunction

  task automatic wait_issued(input int target, input int budget, input bit toggle);
    int n = 0;
    while (issued_cnt < target && n < budget) begin
      if (toggle) ready = ~ready;
      tick();
      n++;
    end
    check("issued_wait", 128'(issued_cnt >= target), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, ib, s0, pc[3], f;
    rst = 1'b0; start_wb = 1'b0; force_valid = 1'b0; ready = 1'b0;
    nb_id = '0; force_x = '0; force_y = '0; force_z = '0;
    ref_force_valid = '0; ref_id = '0;
    ref_force_x = '0; ref_force_y = '0; ref_force_z = '0;
    tick(); tick();
    check("rst_wb_valid", 128'(wb_valid), 0);
    check("rst_wb_out", 128'(wb_out), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_issued", 128'(all_ref_wb_issued), 0);
    check("rst_flags", {nb_overflow, ref_drop}, 0);
    rst = 1'b1;
    tick();

    // Neighbour stream, ready held high.
    ready = 1'b1;
    b = beats.size();
    for (int k = 0; k < 3; k++) begin
      drive_nb(IW'(16'h01A5 + k));
      pc[k] = cyc;
      tick();
    end
    force_valid = 1'b0;
    repeat (6) tick();
    check("nb_count", 128'(beats.size() - b), 3);
    for (int k = 0; k < 3; k++) begin
      check("nb_data", beats[b+k], nb_pkt(IW'(16'h01A5 + k)));
      check("nb_latency", 128'(beat_cyc[b+k] - pc[k]), 2);
    end
    check("nb_no_flags", {nb_overflow, ref_drop}, 0);

    // Backpressure: 10 forces into an 8-deep FIFO behind a held output.
    ready = 1'b0;
    b = beats.size();
    for (int k = 0; k < 10; k++) begin
      drive_nb(IW'(16'h0200 + k));
      tick();
      if (k == 3) check("bp_hold_early", wb_out, nb_pkt(IW'(16'h0200)));
      if (k == 8) check("bp_ovf_before", 128'(nb_overflow), 0);
    end
    force_valid = 1'b0;
    check("bp_ovf_after", 128'(nb_overflow), 1);
    check("bp_hold_vld", 128'(wb_valid), 1);
    check("bp_hold_late", wb_out, nb_pkt(IW'(16'h0200)));
    check("bp_no_beat", 128'(beats.size() - b), 0);
    ready = 1'b1;
    repeat (15) tick();
    check("bp_count", 128'(beats.size() - b), 9);
    for (int k = 0; k < 9; k++) check("bp_order", beats[b+k], nb_pkt(IW'(16'h0200 + k)));

    // Full capture: phase 0 then phase 1, then a complete burst.
    drive_ref(8'h10, IW'(16'h1000), '1, 1'b1);
    drive_ref(8'h20, IW'(16'h2000), '1, 1'b0);
    b = beats.size(); ib = issued_cnt;
    start_wb = 1'b1; s0 = cyc;
    tick();
    start_wb = 1'b0;
    check("full_busy", 128'(busy), 1);
    wait_issued(ib + 1, 80, 1'b0);
    repeat (4) tick();
    check("full_count", 128'(beats.size() - b), NS);
    for (int s = 0; s < NS; s++) begin
      if (s < NF-1) check("full_slot", beats[b+s], ref_pkt(8'h10, IW'(16'h1000), s + 1));
      else          check("full_slot", beats[b+s], ref_pkt(8'h20, IW'(16'h2000), s - (NF-1)));
    end
    check("full_wait_gap", 128'(beat_cyc[b] - s0 >= 7), 1);
    check("full_pulse_once", 128'(issued_cnt - ib), 1);
    check("full_idle", 128'(busy), 0);

    // Sparse: slot 2 (phase 0, ch 3) and slot 9 (phase 1, ch 3), ready toggling.
    drive_ref(8'h30, IW'(16'h3000), 7'b0001001, 1'b1);
    drive_ref(8'h40, IW'(16'h4000), 7'b0001000, 1'b0);
    b = beats.size(); ib = issued_cnt;
    ready = 1'b1; start_wb = 1'b1; s0 = cyc;
    tick();
    start_wb = 1'b0;
    wait_issued(ib + 1, 80, 1'b1);
    ready = 1'b1;
    repeat (4) tick();
    check("sparse_count", 128'(beats.size() - b), 2);
    check("sparse_slot2", beats[b], ref_pkt(8'h30, IW'(16'h3000), 3));
    check("sparse_slot9", beats[b+1], ref_pkt(8'h40, IW'(16'h4000), 3));
`ifndef FD_SKIP_EMPTY_EN
    check("sparse_min_len", 128'(iss_cyc - s0 >= 20), 1);
`endif

    // Neighbour traffic every 3rd cycle holds the burst off.
    b = beats.size(); ib = issued_cnt;
    start_wb = 1'b1;
    tick();
    start_wb = 1'b0;
    f = 0;
    for (int k = 0; k < 39; k++) begin
      if (k % 3 == 0) begin
        drive_nb(IW'(16'h0300 + k));
        f = cyc;
      end else begin
        force_valid = 1'b0;
      end
      tick();
    end
    force_valid = 1'b0;
    check("wait_held_busy", 128'(busy), 1);
    check("wait_held_no_pulse", 128'(issued_cnt - ib), 0);
    while (cyc < f + DROP_AT) tick();
    check("drop_busy", 128'(busy), 1);
    check("drop_before", 128'(ref_drop), 0);
    drive_ref(8'h50, IW'(16'h5000), '1, 1'b1);
    wait_issued(ib + 1, 40, 1'b0);
    repeat (3) tick();
    check("drop_after", 128'(ref_drop), 1);
    check("wait_nb_beats", 128'(beats.size() - b), 13);

    // Dropped references must not appear in a later burst.
    b = beats.size(); ib = issued_cnt;
    start_wb = 1'b1;
    tick();
    start_wb = 1'b0;
    wait_issued(ib + 1, 40, 1'b0);
    repeat (3) tick();
    check("drop_not_captured", 128'(beats.size() - b), 0);

    // Reset in the middle of a stalled burst.
    drive_ref(8'h60, IW'(16'h6000), 7'b0000111, 1'b1);
    ready = 1'b0;
    start_wb = 1'b1;
    tick();
    start_wb = 1'b0;
    repeat (11) tick();
    check("mid_busy", 128'(busy), 1);
    check("mid_vld", 128'(wb_valid), 1);
    rst = 1'b0;
    #1;
    check("arst_wb_valid", 128'(wb_valid), 0);
    check("arst_wb_out", 128'(wb_out), 0);
    check("arst_busy", 128'(busy), 0);
    check("arst_flags", {all_ref_wb_issued, nb_overflow, ref_drop}, 0);
    tick(); tick();
    rst = 1'b1;
    ready = 1'b1;
    tick();
    b = beats.size(); ib = issued_cnt;
    start_wb = 1'b1;
    tick();
    start_wb = 1'b0;
    wait_issued(ib + 1, 40, 1'b0);
    repeat (3) tick();
    check("empty_no_beats", 128'(beats.size() - b), 0);
    check("empty_pulse_once", 128'(issued_cnt - ib), 1);

    check("hold_stable", 128'(hold_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/force_wb_distributor.md
Name: force_wb_distributor

Overview:
- Successor force distributor that sits between the NUM_FILTER-wide RL/LJ evaluation outputs and the write-back bus to the force caches.
- Neighbour forces stream out through an internal FIFO with a proper valid/ready handshake.
- Reference-particle forces are captured into 2*NUM_FILTER-1 slots, selected by phase, and written back in a burst when start_wb is received.
- Adds backpressure-safe output holding, overflow and drop flags, and clearing of slots after write-back.

Parameters:
- DATA_WIDTH, 32, width of one force component
- CELL_ID_WIDTH, 3, width of one cell coordinate
- PARTICLE_ID_WIDTH, 7, width of the particle index
- NUM_FILTER, 7, number of reference-force channels
- ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, width of the full particle id
- WB_WIDTH, ID_WIDTH+3*DATA_WIDTH, width of the write-back packet {id,z,y,x}
- NUM_SLOTS, 2*NUM_FILTER-1, number of reference slots
- NB_FIFO_DEPTH, 8, depth of the neighbour FIFO (power of 2, at least 2)
- WAIT_CYCLES, 5, number of quiet cycles required before the reference burst
- HOME_CELL, 9'b010010010, cell id that marks phase 0

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start_wb  in  1  pulse; request a reference write-back
- ref_force_x/y/z  in  NUM_FILTER x DATA_WIDTH  reference force components
- ref_id  in  NUM_FILTER x ID_WIDTH  reference particle ids
- ref_force_valid  in  NUM_FILTER  per-channel valid
- force_x/y/z  in  DATA_WIDTH  neighbour force components
- nb_id  in  ID_WIDTH  neighbour particle id
- force_valid  in  1  neighbour force valid
- ready  in  1  bus accepts wb_out this cycle
- wb_out  out  WB_WIDTH  packet {id,z,y,x}
- wb_valid  out  1  wb_out is valid
- all_ref_wb_issued  out  1  one-cycle pulse at the end of the burst
- busy  out  1  high while in WAIT or WB_REF
- nb_overflow  out  1  sticky; a neighbour force was lost to a full FIFO
- ref_drop  out  1  sticky; reference valid arrived during WB_REF

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all slot valids 0, FIFO empty, counter 0, state ACTIVE.
- Output register: a beat transfers when wb_valid&&ready. While wb_valid&&!ready, wb_out and wb_valid hold stable. Load new data only when the register is empty or transferring.
- Neighbour path: force_valid pushes {nb_id,z,y,x} into the FIFO.
  - A push into a full FIFO is dropped and sets nb_overflow.
  - A push and a pop in the same cycle while full is allowed.
  - Latency from push to wb_valid is 2 cycles when the FIFO is empty and the output is free.
- Capture (ACTIVE and WAIT only). Phase 0 holds when ref_force_valid[0] is set and ref_id[0] cell field == HOME_CELL; otherwise phase 1.
  - Phase 0: channel i≥1 goes to slot i-1; channel 0 is discarded.
  - Phase 1: channel 0 goes to slot NF-1; channel i≥1 goes to slot i+NF-1.
  - Rewriting an already-valid slot overwrites it (last write wins).
- FSM:
  - ACTIVE: drain the FIFO to the output. On start_wb, clear the counter and go to WAIT. start_wb in other states is ignored.
  - WAIT: keep draining. The counter resets on force_valid or when the FIFO is not empty, and increments otherwise. Go to WB_REF when counter==WAIT_CYCLES and the FIFO is empty.
  - WB_REF: the reference output has priority over the FIFO; neighbour pushes are still accepted.
    - Walk the slots from index 0 upward, emitting only valid slots. Advance on each handshake.
    - Clear each slot's valid as it is accepted.
    - After the last emitted slot is accepted, or immediately if no slot is valid, pulse all_ref_wb_issued for 1 cycle and return to ACTIVE.
  - Any ref_force_valid seen in WB_REF is ignored and sets ref_drop.
- Simultaneous capture and clear of the same slot cannot occur, because capture is disabled in WB_REF.

Optional Feature:
- Macro FD_SKIP_EMPTY_EN.
- Defined: WB_REF skips invalid slots using a priority encoder. Burst length equals the number of valid slots.
- Undefined: WB_REF steps through every slot 0..NUM_SLOTS-1, one slot per cycle.
  - Valid slots are handshaked as normal.
  - Invalid slots cost one cycle with wb_valid=0.
  - The burst always takes at least NUM_SLOTS cycles.

Decomposition:
- Package md_force_pkg: wb_pkt_t struct {id,fz,fy,fx}, the ID_WIDTH/WB_WIDTH derivations, and the HOME_CELL constant.
- One sub-module: fd_sync_fifo, a parametrised-width/depth synchronous FIFO with full/empty outputs, the same clock and the same async active-low reset.

Test Plan:
- nb stream, ready=1: force_valid on 3 cycles with nb_id=0x1A5,0x1A6,0x1A7 -> three beats in order, each 2 cycles after its push; no flags.
- Backpressure: ready=0 for 10 cycles while 10 nb forces arrive (depth 8) -> wb_out stays stable, 1 force is lost (FIFO full, output register held), nb_overflow=1; the remaining forces drain in order.
- Phase 0 then phase 1 capture on all channels, then start_wb -> WB_REF entered after 5 quiet cycles; 13 beats in slot order, ids matching the mapping; all_ref_wb_issued pulses once.
- Sparse slots: only slots 2 and 9 valid, ready toggling 1/0 -> 2 beats, each held until ready; with FD_SKIP_EMPTY_EN undefined, the burst takes at least 13 cycles.
- force_valid every 3rd cycle during WAIT -> never enters WB_REF until the gap exceeds WAIT_CYCLES; ref_force_valid during WB_REF sets ref_drop.
- rst asserted mid-WB_REF -> all outputs 0 immediately; after release, start_wb with no captures gives an all_ref_wb_issued pulse with no beats.
